// File: rtl/c_ingress_arb_if.sv
// Ready/valid channel carrying one cSt beat.
// The source drives valid and data, and holds them stable until rdy.
interface rdy_vld_if #(
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              rdy;
  logic [DATA_W-1:0] data;

  modport src (output valid, output data, input rdy);
  modport dst (input valid, input data, output rdy);
endinterface

// File: rtl/c_ingress_arb.sv
// Round-robin ingress arbiter in front of blockC's eh2c channel.
// One requester owns the channel at a time for up to MAX_BURST beats.
// Accepted beats pass through a one-entry output register.
module c_ingress_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 32,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          rst,
  rdy_vld_if.dst        req [NUM_REQ],
  rdy_vld_if.src        c_out,
  output logic [GW-1:0] cur_grant,
  output logic          grant_active,
  output logic [15:0]   total_beats
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [GW-1:0]     cur_grant_reg, cur_grant_next;
  logic [GW-1:0]     last_grant_reg, last_grant_next;
  logic [BW-1:0]     burst_cnt_reg, burst_cnt_next;
  logic [15:0]       total_beats_reg;
  logic              out_vld_reg;
  logic [DATA_W-1:0] out_data_reg;

  // Flattened views of the requester interface array.
  logic [NUM_REQ-1:0] req_valid;
  logic [DATA_W-1:0]  req_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_rdy;

  // Round-robin search results.
  logic [GW:0]   cand;
  logic          pick_found;
  logic [GW-1:0] pick_idx;

  // Signals for the granted requester.
  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              grant_rdy;
  logic              accept;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_valid[gi] = req[gi].valid;
      assign req_data[gi]  = req[gi].data;
      assign req[gi].rdy   = req_rdy[gi];
    end
  endgenerate

  assign sel_valid = req_valid[cur_grant_reg];
  assign sel_data  = req_data[cur_grant_reg];
  // The output register can take a beat when it is empty or being drained.
  assign grant_rdy = !out_vld_reg || c_out.rdy;

  // Search starting just after the last granted index, wrapping modulo NUM_REQ.
  always_comb begin
    cand       = '0;
    pick_found = 1'b0;
    pick_idx   = last_grant_reg;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant_reg} + (GW + 1)'(k);
      if (cand >= (GW + 1)'(NUM_REQ)) begin
        cand = cand - (GW + 1)'(NUM_REQ);
      end
      if (!pick_found && req_valid[cand[GW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[GW-1:0];
      end
    end
  end

  // Next-state logic, requester ready and accept decode.
  always_comb begin
    state_next      = state_reg;
    cur_grant_next  = cur_grant_reg;
    last_grant_next = last_grant_reg;
    burst_cnt_next  = burst_cnt_reg;
    req_rdy         = '0;
    accept          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          cur_grant_next = pick_idx;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        req_rdy[cur_grant_reg] = grant_rdy;
        if (!sel_valid) begin
          // Requester went quiet: release without taking a beat.
          state_next      = IDLE;
          last_grant_next = cur_grant_reg;
        end else if (grant_rdy) begin
          accept = 1'b1;
          if (burst_cnt_reg == BW'(MAX_BURST - 1)) begin
            // Burst allowance used up; counter restarts from zero.
            state_next      = IDLE;
            last_grant_next = cur_grant_reg;
            burst_cnt_next  = '0;
          end else begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      cur_grant_reg  <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      cur_grant_reg  <= cur_grant_next;
      last_grant_reg <= last_grant_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

  // Output register: an accept reloads it, otherwise a downstream take empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_reg  <= 1'b0;
      out_data_reg <= '0;
    end else if (accept) begin
      out_vld_reg  <= 1'b1;
      out_data_reg <= sel_data;
    end else if (out_vld_reg && c_out.rdy) begin
      out_vld_reg  <= 1'b0;
    end
  end

  // Free-running count of accepted beats; wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      total_beats_reg <= '0;
    end else if (accept) begin
      total_beats_reg <= total_beats_reg + 16'd1;
    end
  end

  assign c_out.valid  = out_vld_reg;
  assign c_out.data   = out_data_reg;
  assign cur_grant    = cur_grant_reg;
  assign grant_active = (state_reg == GRANT);
  assign total_beats  = total_beats_reg;

endmodule
